// File: rtl/oam_dma_if.sv
// CPU-bus / DMA-bus bundle between the sprite DMA sequencer and the rest of the system.
// The master modport is the DMA block; the slave modport is the CPU/PPU side.
interface oam_dma_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        odd_or_even;
  logic [7:0]  mem_rdata;
  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic        dma_wr;
  logic [7:0]  dma_dout;
  logic        dma_done;

  modport master (
    input  bus_addr, bus_din, bus_wr, odd_or_even, mem_rdata,
    output dma_hijack, dma_addr, dma_wr, dma_dout, dma_done
  );

  modport slave (
    output bus_addr, bus_din, bus_wr, odd_or_even, mem_rdata,
    input  dma_hijack, dma_addr, dma_wr, dma_dout, dma_done
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite-memory DMA sequencer: a write to $4014 halts the CPU and copies one
// 256-byte page into OAM through $2004, one read/write pair per byte.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic       cpu_clk,
  input  logic       reset_n,
  oam_dma_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  page_r, page_s;
  logic [7:0]  idx_r, idx_s;
  logic [7:0]  data_q_r, data_q_s;
  logic        trigger_s;

  logic        hijack_r, hijack_s;
  logic        wr_r, wr_s;
  logic        done_r, done_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  dout_r, dout_s;

  // Next-state and datapath update; triggers only count in IDLE/DONE so page stays frozen while hijacking.
  always_comb begin
    state_s   = state_r;
    page_s    = page_r;
    idx_s     = idx_r;
    data_q_s  = data_q_r;
    trigger_s = bus.bus_wr && (bus.bus_addr == DMA_REG_ADDR);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (trigger_s) begin
          page_s  = bus.bus_din;
          idx_s   = 8'd0;
          state_s = ST_HALT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (bus.odd_or_even) begin
          state_s = ST_ALIGN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_ALIGN: state_s = ST_READ;
      ST_READ: begin
        data_q_s = bus.mem_rdata;
        state_s  = ST_WRITE;
      end
      ST_WRITE: begin
        idx_s = idx_r + 8'd1;
        if (idx_r == 8'hFF) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_READ;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they can be registered without adding latency.
  always_comb begin
    hijack_s = 1'b0;
    wr_s     = 1'b0;
    done_s   = 1'b0;
    addr_s   = 16'h0000;
    dout_s   = 8'h00;
    case (state_s)
      ST_HALT, ST_ALIGN: hijack_s = 1'b1;
      ST_READ: begin
        hijack_s = 1'b1;
        addr_s   = {page_s, idx_s};
      end
      ST_WRITE: begin
        hijack_s = 1'b1;
        wr_s     = 1'b1;
        addr_s   = OAM_DATA_ADDR;
        dout_s   = data_q_s;
      end
      ST_DONE: done_s = 1'b1;
      default: hijack_s = 1'b0;
    endcase
  end

  // State, datapath and output registers; async reset releases the bus without a clock.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      page_r   <= 8'd0;
      idx_r    <= 8'd0;
      data_q_r <= 8'd0;
      hijack_r <= 1'b0;
      wr_r     <= 1'b0;
      done_r   <= 1'b0;
      addr_r   <= 16'h0000;
      dout_r   <= 8'h00;
    end else begin
      state_r  <= state_s;
      page_r   <= page_s;
      idx_r    <= idx_s;
      data_q_r <= data_q_s;
      hijack_r <= hijack_s;
      wr_r     <= wr_s;
      done_r   <= done_s;
      addr_r   <= addr_s;
      dout_r   <= dout_s;
    end
  end

  assign bus.dma_hijack = hijack_r;
  assign bus.dma_wr     = wr_r;
  assign bus.dma_done   = done_r;
  assign bus.dma_addr   = addr_r;
  assign bus.dma_dout   = dout_r;

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma: full transfers, alignment, page $FF,
// retriggers, mid-transfer reset and non-trigger bus traffic.
module tb_oam_dma;

  logic cpu_clk;
  logic reset_n;
  int   checks;
  int   failures;

  logic [7:0] mem [0:65535];

  oam_dma_if bus_if ();

  oam_dma dut (
    .cpu_clk (cpu_clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  assign bus_if.mem_rdata = mem[bus_if.dma_addr];

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic [26:0] obs;
  assign obs = {bus_if.dma_hijack, bus_if.dma_wr, bus_if.dma_done, bus_if.dma_addr, bus_if.dma_dout};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hand-chosen page contents
  function automatic logic [7:0] exp_byte(input logic [7:0] page, input logic [7:0] i);
    case (page)
      8'h02:   exp_byte = i ^ 8'h5A;
      8'h07:   exp_byte = ~i;
      8'hFF:   exp_byte = i ^ 8'hC3;
      default: exp_byte = 8'h00;
    endcase
  endfunction

  // Expected {hijack,wr,done,addr,dout} in cycle k after the trigger edge (k=0 is HALT)
  function automatic logic [26:0] exp_vec(input logic [7:0] page, input int a, input int k);
    int j;
    logic [7:0] n;
    if (k <= a) begin
      exp_vec = {1'b1, 1'b0, 1'b0, 16'h0000, 8'h00};
    end else if (k <= 512 + a) begin
      j = k - 1 - a;
      n = 8'(j >> 1);
      if ((j % 2) == 0) exp_vec = {1'b1, 1'b0, 1'b0, page, n, 8'h00};
      else              exp_vec = {1'b1, 1'b1, 1'b0, 16'h2004, exp_byte(page, n)};
    end else if (k == 513 + a) begin
      exp_vec = {1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
    end else begin
      exp_vec = 27'd0;
    end
  endfunction

  task automatic idle_inputs();
    bus_if.bus_wr      = 1'b0;
    bus_if.bus_addr    = 16'h0000;
    bus_if.bus_din     = 8'h00;
    bus_if.odd_or_even = 1'b0;
  endtask

  // One complete transfer, checking every cycle from HALT through the cycle after DONE.
  task automatic run_xfer(input logic [7:0] page, input bit odd, input bit retrig,
                          input bit done_trig, input bit skip_trig);
    int a;
    int last;
    a = odd ? 1 : 0;
    if (!skip_trig) begin
      @(negedge cpu_clk);
      bus_if.bus_addr = 16'h4014;
      bus_if.bus_din  = page;
      bus_if.bus_wr   = 1'b1;
      bus_if.odd_or_even = 1'b0;
      @(posedge cpu_clk);
      #1;
    end
    last = done_trig ? 513 + a : 514 + a;
    for (int k = 0; k <= last; k++) begin
      check_val($sformatf("xfer_p%02h_o%0d_k%0d", page, a, k), {5'd0, obs}, {5'd0, exp_vec(page, a, k)});
      bus_if.odd_or_even = (k == 0) ? odd : 1'b0;
      bus_if.bus_addr    = 16'h4014;
      bus_if.bus_din     = 8'h07;
      bus_if.bus_wr      = (retrig && (k == 201 || k == 512 + a)) || (done_trig && k == 513 + a);
      if (k < last) begin
        @(posedge cpu_clk);
        #1;
      end
    end
    if (done_trig) begin
      @(posedge cpu_clk);
      #1;
    end else begin
      idle_inputs();
    end
  endtask

  // Single-cycle bus access that must not start a transfer
  task automatic no_trigger(input string tag, input logic [15:0] addr, input logic wr);
    @(negedge cpu_clk);
    bus_if.bus_addr = addr;
    bus_if.bus_din  = 8'h02;
    bus_if.bus_wr   = wr;
    @(posedge cpu_clk);
    #1;
    idle_inputs();
    check_val({tag, "_c1"}, {5'd0, obs}, 32'd0);
    @(posedge cpu_clk);
    #1;
    check_val({tag, "_c2"}, {5'd0, obs}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0700 + i] = ~8'(i);
      mem[16'hFF00 + i] = 8'(i) ^ 8'hC3;
    end
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check_val("reset_outputs", {5'd0, obs}, 32'd0);
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    @(posedge cpu_clk);
    #1;
    check_val("post_reset_idle", {5'd0, obs}, 32'd0);

    no_trigger("wr_4013", 16'h4013, 1'b1);
    no_trigger("wr_4015", 16'h4015, 1'b1);
    no_trigger("rd_4014", 16'h4014, 1'b0);

    run_xfer(8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    run_xfer(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge cpu_clk);
    #1;
    check_val("pageff_back_idle", {5'd0, obs}, 32'd0);

    run_xfer(8'h02, 1'b0, 1'b1, 1'b1, 1'b0);
    run_xfer(8'h07, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset between edges during byte 40's WRITE
    @(negedge cpu_clk);
    bus_if.bus_addr = 16'h4014;
    bus_if.bus_din  = 8'h02;
    bus_if.bus_wr   = 1'b1;
    @(posedge cpu_clk);
    #1;
    idle_inputs();
    repeat (82) @(posedge cpu_clk);
    #1;
    check_val("mid_byte40_write", {5'd0, obs}, {5'd0, 1'b1, 1'b1, 1'b0, 16'h2004, 8'h72});
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_reset_drop", {5'd0, obs}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge cpu_clk);
      #1;
      check_val($sformatf("in_reset_c%0d", c), {5'd0, obs}, 32'd0);
    end
    @(negedge cpu_clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge cpu_clk);
      #1;
      check_val($sformatf("after_reset_c%0d", c), {5'd0, obs}, 32'd0);
    end
    run_xfer(8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-memory DMA sequencer for the PPU. A CPU write of a page number to $4014 halts the CPU and copies the 256 bytes at page×$100 into OAM through the PPU's OAMDATA port ($2004), one read/write pair per byte. It sits between the CPU bus and the PPU register decode, drives the PPU's `dma_hijack`/`dma_addr` path, and is the only block that takes the bus from the CPU.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014: CPU address that triggers a transfer.
- `OAM_DATA_ADDR`, 16'h2004: destination address driven on every write cycle.

Ports:
- `cpu_clk`  in  1  CPU clock; one clock, all state on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `bus_addr`  in  16  CPU address.
- `bus_din`  in  8  CPU write data.
- `bus_wr`  in  1  CPU write strobe, active-high.
- `odd_or_even`  in  1  CPU cycle parity: 1 on odd cycles.
- `mem_rdata`  in  8  CPU-space read data for `dma_addr`; must be valid by the end of a READ cycle.
- `dma_hijack`  out  1  CPU halted; the bus is owned by the DMA.
- `dma_addr`  out  16  DMA bus address.
- `dma_wr`  out  1  DMA write strobe.
- `dma_dout`  out  8  DMA write data.
- `dma_done`  out  1  one-cycle pulse after the last byte is written.

## Operation
- State is held in `state`, a page register (8 bits), a byte index `idx` (8 bits) and a data register `data_q` (8 bits).
- **IDLE**
  - A trigger is `bus_wr && bus_addr==DMA_REG_ADDR` sampled at a clock edge.
  - On a trigger: `page<=bus_din`, `idx<=0`, go to HALT.
- **HALT**
  - `dma_hijack=1`, `dma_wr=0`, `dma_addr=0`. Lasts one cycle.
  - If `odd_or_even==1` in this cycle, go to ALIGN; otherwise go to READ.
- **ALIGN**: dummy cycle, identical outputs to HALT, then go to READ. READ therefore always starts on an even cycle.
- **READ**
  - `dma_hijack=1`, `dma_addr={page,idx}`, `dma_wr=0`.
  - At the end of the cycle: `data_q<=mem_rdata`, go to WRITE.
- **WRITE**
  - `dma_hijack=1`, `dma_addr=OAM_DATA_ADDR`, `dma_wr=1`, `dma_dout=data_q`.
  - At the end of the cycle: `idx<=idx+1` (8-bit wrap).
  - If `idx==8'hFF`, go to DONE; otherwise go to READ.
- **DONE**
  - `dma_hijack=0`, `dma_done=1` for one cycle, then go to IDLE.
  - A trigger seen in DONE is accepted exactly as in IDLE.
- Address arithmetic:
  - `idx` wraps with no carry into `page`. Page $FF reads $FF00–$FFFF and stops.
  - The destination address never changes. The PPU's OAM_ADDR auto-increment handles placement.
- While `dma_hijack=1`, triggers are ignored and `page` is frozen. This covers a CPU write to $4014 in the same cycle the block leaves WRITE.
- `dma_dout` reads 0 outside WRITE. `data_q` holds its value but is not visible.

## Timing
- Reset (`reset_n=0`, asynchronous): state=IDLE, `page=0`, `idx=0`, `data_q=0`.
  - All outputs are 0: `dma_hijack`, `dma_wr`, `dma_done`, `dma_addr=0`, `dma_dout=0`.
  - Reset mid-transfer drops `dma_hijack` immediately, without waiting for a clock. No `dma_done` is produced.
- Trigger edge to the first `dma_hijack=1` cycle: the next cycle (registered).
- Total `dma_hijack` length: 513 cycles (HALT + 512), or 514 when the HALT cycle is odd.
- Byte n:
  - READ occupies cycle H+1+a+2n; WRITE occupies cycle H+2+a+2n.
  - H is the HALT cycle; a=1 if ALIGN occurred, otherwise 0.
- `dma_done` is asserted in the cycle immediately after the final WRITE, with `dma_hijack` already 0.
- Outputs are decoded from registered state only. There is no combinational path from `bus_*` to the outputs.

## Test plan
- **Page $02, even HALT:** preload $0200+i = i^8'h5A.
  - Expect `dma_hijack` high for exactly 513 cycles.
  - Expect 256 writes to $2004 with data i^$5A in order, then one `dma_done` pulse.
- **Odd HALT:** same stimulus with `odd_or_even=1` in the HALT cycle.
  - Expect exactly one ALIGN cycle and 514 hijack cycles.
  - Expect the first READ `dma_addr` = $0200 on an even cycle.
- **Page $FF:**
  - Expect the last READ at $FFFF and no access at $0000.
  - Expect `idx` to return to 0 and the block to return to IDLE.
- **Retrigger during transfer:** write $4014 with $07 at byte 100.
  - Expect the transfer to continue from $0264 with the page unchanged and 513 total cycles.
  - Then write $07 in the DONE cycle: expect a new transfer from $0700.
- **Reset mid-transfer:** pull `reset_n` low between clock edges at byte 40.
  - Expect `dma_hijack`/`dma_wr` to go 0 before the next edge and no `dma_done`.
  - After release, expect a fresh $4014 write to start from `idx=0`.
- **Non-trigger traffic:**
  - Writes to $4013/$4015 and a read of $4014: expect no hijack.
  - Write to $4014 with `bus_wr=0`: expect no hijack.
